// File: rtl/bias_broadcast_engine_pkg.sv
// Shared types and default sizing for the bias broadcast engine.
// Holds the controller state encoding and the job mode encoding.
package bias_broadcast_engine_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_GROUP  = 25;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_RDPIX,
        ST_WAITPIX,
        ST_WRPIX,
        ST_FINISH
    } state_e;

    typedef enum logic {
        MODE_OVERWRITE = 1'b0,
        MODE_ADD       = 1'b1
    } mode_e;

endpackage

// File: rtl/bias_broadcast_engine_if.sv
// Job request and memory read/write bus of the bias broadcast engine.
// master = engine side, slave = controller plus memory side.
interface bias_broadcast_engine_if
    import bias_broadcast_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic                     start;
    logic                     mode;
    logic [ADDR_W-1:0]        bias_base;
    logic [ADDR_W-1:0]        out_base;
    logic [CNT_W-1:0]         num_ch;
    logic [CNT_W-1:0]         out_h;
    logic [CNT_W-1:0]         out_w;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     rd_valid;
    logic signed [DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic                     wr_ready;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, mode, bias_base, out_base, num_ch, out_h, out_w,
        input  rd_valid, rd_data, wr_ready,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        output start, mode, bias_base, out_base, num_ch, out_h, out_w,
        output rd_valid, rd_data, wr_ready,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/bias_broadcast_engine_bias_sat_add.sv
// Combinational signed adder that clamps to the DATA_W two's-complement range.
module bias_sat_add
    import bias_broadcast_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] y
);
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] z
    );
        logic [DATA_W:0] s;
        s = {x[DATA_W-1], x} + {z[DATA_W-1], z};
        // Overflow shows up as the two top bits of the extended sum disagreeing.
        if (s[DATA_W] != s[DATA_W-1])
            return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return s[DATA_W-1:0];
    endfunction

    assign y = sat_add(a, b);
endmodule

// File: rtl/bias_broadcast_engine.sv
// Broadcasts per-channel biases over an output feature map, either overwriting
// each pixel or adding the bias to it; biases are fetched in groups of GROUP.
module bias_broadcast_engine
    import bias_broadcast_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int GROUP  = DEF_GROUP,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    bias_broadcast_engine_if.master bus
);
    localparam int BUF_W = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam int PIX_W = 2 * CNT_W;

    state_e                   state_q, state_d;
    mode_e                    mode_q, mode_d;
    logic [ADDR_W-1:0]        bias_base_q, bias_base_d;
    logic [ADDR_W-1:0]        pix_addr_q, pix_addr_d;
    logic [CNT_W-1:0]         num_ch_q, num_ch_d;
    logic [CNT_W-1:0]         ch_q, ch_d;
    logic [CNT_W-1:0]         load_len_q, load_len_d;
    logic [CNT_W-1:0]         load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]         buf_idx_q, buf_idx_d;
    logic [PIX_W-1:0]         npix_q, npix_d;
    logic [PIX_W-1:0]         pix_q, pix_d;
    logic                     rd_pend_q, rd_pend_d;
    logic                     done_q, done_d;
    logic signed [DATA_W-1:0] sum_q, sum_d;
    logic signed [DATA_W-1:0] buf_q [GROUP];
    logic                     buf_we;
    logic [BUF_W-1:0]         buf_widx;
    logic signed [DATA_W-1:0] cur_bias;
    logic signed [DATA_W-1:0] add_y;
    logic                     advance;
    state_e                   pix_state;

    function automatic logic [CNT_W-1:0] group_len(input logic [CNT_W-1:0] remaining);
        if (remaining > CNT_W'(GROUP))
            return CNT_W'(GROUP);
        return remaining;
    endfunction

    assign cur_bias  = buf_q[buf_idx_q[BUF_W-1:0]];
    assign pix_state = (mode_q == MODE_ADD) ? ST_RDPIX : ST_FILL;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = done_q;

    bias_sat_add #(.DATA_W(DATA_W)) u_sat (
        .a (bus.rd_data),
        .b (cur_bias),
        .y (add_y)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        bias_base_d = bias_base_q;
        pix_addr_d  = pix_addr_q;
        num_ch_d    = num_ch_q;
        ch_d        = ch_q;
        load_len_d  = load_len_q;
        load_cnt_d  = load_cnt_q;
        buf_idx_d   = buf_idx_q;
        npix_d      = npix_q;
        pix_d       = pix_q;
        rd_pend_d   = rd_pend_q;
        sum_d       = sum_q;
        done_d      = 1'b0;
        buf_we      = 1'b0;
        buf_widx    = load_cnt_q[BUF_W-1:0];
        advance     = 1'b0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_d      = mode_e'(bus.mode);
                    bias_base_d = bus.bias_base;
                    pix_addr_d  = bus.out_base;
                    num_ch_d    = bus.num_ch;
                    npix_d      = PIX_W'(bus.out_h) * PIX_W'(bus.out_w);
                    ch_d        = '0;
                    pix_d       = '0;
                    buf_idx_d   = '0;
                    load_cnt_d  = '0;
                    rd_pend_d   = 1'b0;
                    load_len_d  = group_len(bus.num_ch);
                    if (bus.num_ch == '0 || bus.out_h == '0 || bus.out_w == '0)
                        state_d = ST_FINISH;
                    else
                        state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Single outstanding read: the next strobe waits for the return.
                if (!rd_pend_q) begin
                    bus.rd_en   = 1'b1;
                    bus.rd_addr = bias_base_q + ADDR_W'(ch_q) + ADDR_W'(load_cnt_q);
                    rd_pend_d   = 1'b1;
                end else if (bus.rd_valid) begin
                    buf_we     = 1'b1;
                    rd_pend_d  = 1'b0;
                    load_cnt_d = load_cnt_q + CNT_W'(1);
                    if (load_cnt_q + CNT_W'(1) == load_len_q) begin
                        buf_idx_d = '0;
                        pix_d     = '0;
                        state_d   = pix_state;
                    end
                end
            end
            ST_FILL: begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = pix_addr_q;
                bus.wr_data = cur_bias;
                advance     = bus.wr_ready;
            end
            ST_RDPIX: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = pix_addr_q;
                state_d     = ST_WAITPIX;
            end
            ST_WAITPIX: begin
                if (bus.rd_valid) begin
                    sum_d   = add_y;
                    state_d = ST_WRPIX;
                end
            end
            ST_WRPIX: begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = pix_addr_q;
                bus.wr_data = sum_q;
                advance     = bus.wr_ready;
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Channels are laid out back to back, so the output address just counts up.
        if (advance) begin
            pix_addr_d = pix_addr_q + ADDR_W'(1);
            if (pix_q + PIX_W'(1) == npix_q) begin
                pix_d = '0;
                ch_d  = ch_q + CNT_W'(1);
                if (ch_q + CNT_W'(1) == num_ch_q) begin
                    state_d = ST_FINISH;
                end else if (buf_idx_q + CNT_W'(1) == load_len_q) begin
                    buf_idx_d  = '0;
                    load_cnt_d = '0;
                    load_len_d = group_len(num_ch_q - ch_q - CNT_W'(1));
                    state_d    = ST_LOAD;
                end else begin
                    buf_idx_d = buf_idx_q + CNT_W'(1);
                    state_d   = pix_state;
                end
            end else begin
                pix_d   = pix_q + PIX_W'(1);
                state_d = pix_state;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_OVERWRITE;
            bias_base_q <= '0;
            pix_addr_q  <= '0;
            num_ch_q    <= '0;
            ch_q        <= '0;
            load_len_q  <= '0;
            load_cnt_q  <= '0;
            buf_idx_q   <= '0;
            npix_q      <= '0;
            pix_q       <= '0;
            rd_pend_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bias_base_q <= bias_base_d;
            pix_addr_q  <= pix_addr_d;
            num_ch_q    <= num_ch_d;
            ch_q        <= ch_d;
            load_len_q  <= load_len_d;
            load_cnt_q  <= load_cnt_d;
            buf_idx_q   <= buf_idx_d;
            npix_q      <= npix_d;
            pix_q       <= pix_d;
            rd_pend_q   <= rd_pend_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        sum_q <= sum_d;
        if (buf_we)
            buf_q[buf_widx] <= bus.rd_data;
    end
endmodule

// File: tb/tb_bias_broadcast_engine.sv
// Randomized bench for bias_broadcast_engine: a memory model serves reads with
// random latency, and each job is compared against a channel/pixel reference.
module tb_bias_broadcast_engine;
    import bias_broadcast_engine_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int GROUP  = 25;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bias_broadcast_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    bias_broadcast_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .GROUP(GROUP), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem  [65536];
    logic [15:0] mem0 [65536];
    logic [15:0] wlog_addr [$];
    logic [15:0] wlog_data [$];
    logic [15:0] rlog_addr [$];
    int  n_checks, n_errors;
    int  done_cnt, rd_cnt, stall_viol, both_viol;
    bit  rdy_rand;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        logic [31:0] t;
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        t = v;
        return t[15:0];
    endfunction

    // Memory, write acceptor and bus monitor, all sampled on the falling edge.
    initial begin
        int          rcnt;
        logic [15:0] raddr, p_addr, p_data;
        bit          prev_stall;
        rcnt = 0; raddr = '0; p_addr = '0; p_data = '0; prev_stall = 0;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        bus.wr_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (prev_stall && !reset) begin
                if (!bus.wr_en || bus.wr_addr !== p_addr || 16'(bus.wr_data) !== p_data)
                    stall_viol++;
            end
            if (bus.rd_en && bus.wr_en) both_viol++;
            bus.wr_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.wr_en && bus.wr_ready && !reset) begin
                mem[int'(bus.wr_addr)] = bus.wr_data;
                wlog_addr.push_back(bus.wr_addr);
                wlog_data.push_back(bus.wr_data);
            end
            prev_stall = bus.wr_en && !bus.wr_ready && !reset;
            p_addr = bus.wr_addr;
            p_data = bus.wr_data;
            if (bus.rd_en && !reset) begin
                rd_cnt++;
                rlog_addr.push_back(bus.rd_addr);
            end
            if (bus.done) done_cnt++;
            bus.rd_valid = 1'b0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = mem[int'(raddr)];
                end
            end
            if (bus.rd_en && !reset && rcnt == 0 && !bus.rd_valid) begin
                rcnt  = $urandom_range(1, 4);
                raddr = bus.rd_addr;
            end
        end
    end

    task automatic clear_logs();
        wlog_addr.delete();
        wlog_data.delete();
        rlog_addr.delete();
        done_cnt = 0;
        rd_cnt   = 0;
    endtask

    // Reference: channel c, pixel p lands at out_base + c*npix + p, channels in order.
    task automatic verify_job(input bit md, input int bb, input int ob, input int nch,
                              input int h, input int w);
        logic [15:0] ea [$];
        logic [15:0] ed [$];
        logic [15:0] b;
        int npix, a, n;
        npix = h * w;
        for (int c = 0; c < nch; c++) begin
            b = mem0[(bb + c) & 16'hFFFF];
            for (int p = 0; p < npix; p++) begin
                a = (ob + c * npix + p) & 16'hFFFF;
                ea.push_back(16'(a));
                if (md) ed.push_back(sat16(int'($signed(mem0[a])) + int'($signed(b))));
                else    ed.push_back(b);
            end
        end
        check_eq("n_writes", wlog_addr.size(), ea.size());
        check_eq("n_reads", rd_cnt, nch + (md ? nch * npix : 0));
        n = (wlog_addr.size() < ea.size()) ? wlog_addr.size() : ea.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("wr_addr[%0d]", i), wlog_addr[i], ea[i]);
            check_eq($sformatf("wr_data[%0d]", i), wlog_data[i], ed[i]);
        end
        for (int i = 0; i < ea.size(); i++)
            check_eq($sformatf("mem[%0h]", ea[i]), mem[int'(ea[i])], ed[i]);
    endtask

    // Call on a falling edge; start is driven immediately.
    task automatic run_job(input bit md, input int bb, input int ob, input int nch,
                           input int h, input int w, input bit rr, input bit intrude,
                           input bit keep);
        int cyc;
        if (!keep) begin
            for (int c = 0; c < nch; c++) mem[(bb + c) & 16'hFFFF] = 16'($urandom);
            for (int i = 0; i < nch * h * w; i++) mem[(ob + i) & 16'hFFFF] = 16'($urandom);
        end
        mem0 = mem;
        clear_logs();
        rdy_rand      = rr;
        bus.mode      = md;
        bus.bias_base = 16'(bb);
        bus.out_base  = 16'(ob);
        bus.num_ch    = 16'(nch);
        bus.out_h     = 16'(h);
        bus.out_w     = 16'(w);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (intrude) begin
            repeat (3) @(negedge clk);
            bus.mode     = ~md;
            bus.out_base = 16'(ob + 16'h0400);
            bus.num_ch   = 16'd1;
            bus.start    = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check_eq("done_once", done_cnt, 1);
        check_eq("idle_after", bus.busy, 1'b0);
        verify_job(md, bb, ob, nch, h, w);
        rdy_rand = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},    bus.busy,    1'b0);
        check_eq({tag, "_done"},    bus.done,    1'b0);
        check_eq({tag, "_rd_en"},   bus.rd_en,   1'b0);
        check_eq({tag, "_wr_en"},   bus.wr_en,   1'b0);
        check_eq({tag, "_rd_addr"}, bus.rd_addr, 16'h0);
        check_eq({tag, "_wr_addr"}, bus.wr_addr, 16'h0);
        check_eq({tag, "_wr_data"}, 16'(bus.wr_data), 16'h0);
    endtask

    initial begin
        int bb, ob, cyc;
        n_checks = 0; n_errors = 0;
        stall_viol = 0; both_viol = 0;
        done_cnt = 0; rd_cnt = 0; rdy_rand = 0;
        bus.start = 1'b0; bus.mode = 1'b0;
        bus.bias_base = '0; bus.out_base = '0;
        bus.num_ch = '0; bus.out_h = '0; bus.out_w = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");

        // Start issued on the first cycle with reset low.
        reset = 1'b0;
        run_job(1'b0, 16'h0100, 16'h0200, 3, 2, 2, 1'b0, 1'b0, 1'b0);
        check_eq("g30_last_addr", wlog_addr.size() == 12 ? wlog_addr[11] : 16'hDEAD, 16'h020B);
        check_eq("g30_ch1_data", wlog_data.size() == 12 ? wlog_data[4] : 16'hDEAD, mem0[16'h0101]);

        // Two bias groups: 25 then 5 reads.
        run_job(1'b0, 16'h1000, 16'h3000, 30, 1, 1, 1'b0, 1'b0, 1'b0);
        check_eq("g31_reads", rlog_addr.size(), 30);
        check_eq("g31_grp2_addr", rlog_addr.size() > 25 ? rlog_addr[25] : 16'hDEAD, 16'h1019);

        // Saturation in add mode.
        mem[16'h0500] = 16'h0020; mem[16'h0501] = 16'hFFF0;
        mem[16'h0600] = 16'h7FF0; mem[16'h0601] = 16'h8005;
        run_job(1'b1, 16'h0500, 16'h0600, 2, 1, 1, 1'b0, 1'b0, 1'b1);
        check_eq("sat_pos", mem[16'h0600], 16'h7FFF);
        check_eq("sat_neg", mem[16'h0601], 16'h8000);

        // Random jobs with write back-pressure, one wrapping past the top address.
        for (int j = 0; j < 6; j++) begin
            bb = $urandom_range(16'h1000, 16'h2000);
            ob = (j == 0) ? 16'hFFF8 : $urandom_range(16'h8000, 16'hF000);
            run_job(1'($urandom_range(0, 1)), bb, ob, $urandom_range(1, 40),
                    $urandom_range(1, 3), $urandom_range(1, 3), 1'b1, 1'b0, 1'b0);
        end

        // A second start while busy must be ignored.
        run_job(1'b0, 16'h0700, 16'h4000, 3, 2, 2, 1'b1, 1'b1, 1'b0);

        // Empty jobs: no memory traffic, done two cycles after start.
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            bus.num_ch = (k == 0) ? 16'd0 : 16'd4;
            bus.out_h  = 16'd2;
            bus.out_w  = (k == 0) ? 16'd2 : 16'd0;
            bus.start  = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            check_eq($sformatf("zero%0d_busy1", k), bus.busy, 1'b1);
            check_eq($sformatf("zero%0d_done1", k), bus.done, 1'b0);
            @(negedge clk);
            check_eq($sformatf("zero%0d_done2", k), bus.done, 1'b1);
            check_eq($sformatf("zero%0d_busy2", k), bus.busy, 1'b0);
            @(negedge clk);
            check_eq($sformatf("zero%0d_done3", k), bus.done, 1'b0);
            check_eq($sformatf("zero%0d_reads", k), rd_cnt, 0);
            check_eq($sformatf("zero%0d_writes", k), wlog_addr.size(), 0);
        end

        // Reset in the middle of a fill, then a fresh job.
        clear_logs();
        bus.mode = 1'b0; bus.bias_base = 16'h0800; bus.out_base = 16'h5000;
        bus.num_ch = 16'd5; bus.out_h = 16'd4; bus.out_w = 16'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.wr_en && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("fill_reached", bus.wr_en, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        reset = 1'b0;
        run_job(1'b1, 16'h0900, 16'h6000, 4, 3, 2, 1'b1, 1'b0, 1'b0);

        check_eq("stall_hold", stall_viol, 0);
        check_eq("rd_wr_excl", both_viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
